// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
// Registers the winning operands, captures ALU result/flags a cycle later, returns them per requester.
module alu_arbiter #(
  parameter int DATA_W  = 4,
  parameter int NUM_OPS = 10
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iReq0Valido,
  input  logic              iReq1Valido,
  input  logic [3:0]        ivInst0,
  input  logic [3:0]        ivInst1,
  input  logic [DATA_W-1:0] ivA0,
  input  logic [DATA_W-1:0] ivB0,
  input  logic [DATA_W-1:0] ivA1,
  input  logic [DATA_W-1:0] ivB1,
  output logic              oReq0Listo,
  output logic              oReq1Listo,
  output logic              oResp0Valido,
  output logic              oResp1Valido,
  output logic [DATA_W-1:0] ovResultado0,
  output logic [DATA_W-1:0] ovResultado1,
  output logic [DATA_W-1:0] ovFlags0,
  output logic [DATA_W-1:0] ovFlags1,
  output logic              oError0,
  output logic              oError1,
  input  logic              iResp0Listo,
  input  logic              iResp1Listo,
  output logic [3:0]        ovAluInstruccion,
  output logic [DATA_W-1:0] ovAluRegistroA,
  output logic [DATA_W-1:0] ovAluRegistroB,
  input  logic [DATA_W-1:0] ivAluResultado,
  input  logic [DATA_W-1:0] ivAluFlags,
  output logic              oOcupado
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST_OP = 4'(NUM_OPS - 1);

  state_t state, state_next;
  logic   prio, owner;
  logic   grant0, grant1, accept, resp_ack, illegal;

  assign grant0   = iReq0Valido && (!iReq1Valido || !prio);
  assign grant1   = iReq1Valido && (!iReq0Valido || prio);
  assign accept   = (state == IDLE) && (grant0 || grant1);
  assign resp_ack = owner ? iResp1Listo : iResp0Listo;
  assign illegal  = ovAluInstruccion > LAST_OP;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is masked during reset so every output reads 0 while it is held.
  always_comb begin
    oReq0Listo   = (state == IDLE) && grant0 && !iReset;
    oReq1Listo   = (state == IDLE) && grant1 && !iReset;
    oResp0Valido = (state == RESP) && !owner;
    oResp1Valido = (state == RESP) && owner;
    oOcupado     = (state != IDLE);
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      prio             <= 1'b0;
      owner            <= 1'b0;
      ovAluInstruccion <= '0;
      ovAluRegistroA   <= '0;
      ovAluRegistroB   <= '0;
      ovResultado0     <= '0;
      ovFlags0         <= '0;
      oError0          <= 1'b0;
      ovResultado1     <= '0;
      ovFlags1         <= '0;
      oError1          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner            <= grant1;
          ovAluInstruccion <= grant1 ? ivInst1 : ivInst0;
          ovAluRegistroA   <= grant1 ? ivA1 : ivA0;
          ovAluRegistroB   <= grant1 ? ivB1 : ivB0;
        end
        EXEC: begin
          if (owner) begin
            ovResultado1 <= illegal ? '0 : ivAluResultado;
            ovFlags1     <= illegal ? '0 : ivAluFlags;
            oError1      <= illegal;
          end else begin
            ovResultado0 <= illegal ? '0 : ivAluResultado;
            ovFlags0     <= illegal ? '0 : ivAluFlags;
            oError0      <= illegal;
          end
        end
        RESP: if (resp_ack) begin
          // Clearing on consumption keeps the idle channel's response at 0.
          prio <= ~owner;
          if (owner) begin
            ovResultado1 <= '0;
            ovFlags1     <= '0;
            oError1      <= 1'b0;
          end else begin
            ovResultado0 <= '0;
            ovFlags0     <= '0;
            oError0      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
